// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: five-state FSM that sequences fetch,
// decode, execute, memory and write-back, and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        ext_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  // state  | meaning
  // FETCH  | read instruction, load IR and PC+4 on mem_ready
  // DECODE | route by opcode; j completes here, unsupported ops flagged
  // EXEC   | ALU operation; jr and beq complete here
  // MEM    | data read (lw) or write (sw), held until mem_ready
  // WB     | register-file write; jal also redirects the PC
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_RS   = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] retired_q;
  logic        retire;

  logic is_rtype, is_jr, is_r_alu, is_lw, is_sw, is_beq;
  logic is_addiu, is_ori, is_lui, is_j, is_jal, op_ok;
  logic [2:0] r_alu;

  logic pc_we_c, ir_we_c, mem_rd_c, mem_wr_c, reg_we_c, illegal_c;

  always_comb begin
    r_alu    = ALU_ADD;
    is_r_alu = 1'b1;
    case (funct)
      6'b100001: r_alu = ALU_ADD;
      6'b100011: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   is_r_alu = 1'b0;
    endcase
  end

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_addiu = (opcode == OP_ADDIU);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign op_ok    = (is_rtype && (is_r_alu || is_jr)) || is_lw || is_sw ||
                    is_beq || is_addiu || is_ori || is_lui;

  always_comb begin
    state_d   = S_FETCH;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    reg_we_c  = 1'b0;
    illegal_c = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    pc_src    = 2'b00;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_c = 1'b1;
        state_d  = S_FETCH;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we_c = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
        end else if (is_jal) begin
          state_d = S_WB;
        end else if (op_ok) begin
          state_d = S_EXEC;
        end else begin
          illegal_c = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_jr) begin
          pc_we_c = 1'b1;
          pc_src  = PC_RS;
          retire  = 1'b1;
        end else if (is_rtype && is_r_alu) begin
          alu_op  = r_alu;
          state_d = S_WB;
        end else if (is_lw || is_sw || is_addiu) begin
          alu_src_b = 1'b1;
          ext_op    = 1'b1;
          state_d   = is_addiu ? S_WB : S_MEM;
        end else if (is_ori) begin
          alu_op    = ALU_OR;
          alu_src_b = 1'b1;
          state_d   = S_WB;
        end else if (is_lui) begin
          alu_op    = ALU_LUI;
          alu_src_b = 1'b1;
          state_d   = S_WB;
        end else if (is_beq) begin
          // pc_src names the branch path throughout; zero alone decides the write
          alu_op  = ALU_SUB;
          pc_we_c = zero;
          pc_src  = PC_BR;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        mem_rd_c = is_lw;
        mem_wr_c = is_sw;
        if (is_lw || is_sw) begin
          if (!mem_ready)  state_d = S_MEM;
          else if (is_lw)  state_d = S_WB;
          else             retire  = 1'b1;
        end
      end
      S_WB: begin
        retire = 1'b1;
        if (is_rtype && is_r_alu) begin
          reg_we_c = 1'b1;
          reg_dst  = 2'b01;
        end else if (is_addiu || is_ori || is_lui) begin
          reg_we_c = 1'b1;
        end else if (is_lw) begin
          reg_we_c = 1'b1;
          wb_sel   = 2'b01;
        end else if (is_jal) begin
          reg_we_c = 1'b1;
          reg_dst  = 2'b10;
          wb_sel   = 2'b10;
          pc_we_c  = 1'b1;
          pc_src   = PC_JUMP;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  // Strobes are gated by rst_n so an asserted reset silences them without a clock.
  assign pc_we   = pc_we_c   & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign mem_rd  = mem_rd_c  & rst_n;
  assign mem_wr  = mem_wr_c  & rst_n;
  assign reg_we  = reg_we_c  & rst_n;
  assign illegal = illegal_c & rst_n;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction model queues the
// expected per-cycle control vector, each test drains and compares it.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_we, ir_we, mem_rd, mem_wr, reg_we, alu_src_b, ext_op, illegal;
  logic [1:0]  reg_dst, wb_sel, pc_src;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_src(pc_src),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we, ir_we, mem_rd, mem_wr, reg_we;
    logic [1:0] reg_dst, wb_sel;
    logic [2:0] alu_op;
    logic       alu_src_b, ext_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       mr, zr;
    logic [5:0] op, fn;
    ctl_t       e;
  } cyc_t;

  cyc_t        sb[$];
  logic [31:0] exp_ret;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic cyc_t mk(input logic [2:0] st, input logic mr,
                              input logic [5:0] op, input logic [5:0] fn, input logic z);
    cyc_t c;
    c = '0;
    c.mr = mr; c.zr = z; c.op = op; c.fn = fn; c.e.state = st;
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, written from the ISA table.
  function automatic void push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                     input int fst, input int mst, input bit abort);
    cyc_t c;
    logic [2:0] ra;
    bit r_ok, is_r, jr, lw, sw, beq, addiu, ori, lui, legal;
    ra = 3'd0; r_ok = 1'b1;
    case (fn)
      6'h21: ra = 3'd0;
      6'h23: ra = 3'd1;
      6'h24: ra = 3'd2;
      6'h25: ra = 3'd3;
      6'h2a: ra = 3'd4;
      6'h08: ra = 3'd0;
      default: r_ok = 1'b0;
    endcase
    is_r = (op == 6'h00); jr = is_r && (fn == 6'h08);
    lw = (op == 6'h23); sw = (op == 6'h2b); beq = (op == 6'h04);
    addiu = (op == 6'h09); ori = (op == 6'h0d); lui = (op == 6'h0f);
    legal = (is_r && r_ok) || lw || sw || beq || addiu || ori || lui || op == 6'h02 || op == 6'h03;
    for (int i = 0; i < fst; i++) begin
      c = mk(3'd0, 1'b0, op, fn, z); c.e.mem_rd = 1'b1; sb.push_back(c);
    end
    c = mk(3'd0, 1'b1, op, fn, z);
    c.e.mem_rd = 1'b1; c.e.ir_we = 1'b1; c.e.pc_we = 1'b1;
    sb.push_back(c);
    c = mk(3'd1, 1'b1, op, fn, z);
    if (op == 6'h02) begin
      c.e.pc_we = 1'b1; c.e.pc_src = 2'b10; sb.push_back(c); exp_ret++; return;
    end
    if (!legal) begin
      c.e.illegal = 1'b1; sb.push_back(c); return;
    end
    sb.push_back(c);
    if (op != 6'h03) begin
      c = mk(3'd2, 1'b1, op, fn, z);
      if (jr) begin
        c.e.pc_we = 1'b1; c.e.pc_src = 2'b11; sb.push_back(c); exp_ret++; return;
      end
      if (is_r) c.e.alu_op = ra;
      else if (lw || sw || addiu) begin c.e.alu_src_b = 1'b1; c.e.ext_op = 1'b1; end
      else if (ori) begin c.e.alu_op = 3'd3; c.e.alu_src_b = 1'b1; end
      else if (lui) begin c.e.alu_op = 3'd5; c.e.alu_src_b = 1'b1; end
      else begin
        c.e.alu_op = 3'd1; c.e.pc_we = z; c.e.pc_src = 2'b01; sb.push_back(c); exp_ret++; return;
      end
      sb.push_back(c);
      if (lw || sw) begin
        for (int i = 0; i < mst; i++) begin
          c = mk(3'd3, 1'b0, op, fn, z); c.e.mem_rd = lw; c.e.mem_wr = sw; sb.push_back(c);
        end
        if (abort) return;
        c = mk(3'd3, 1'b1, op, fn, z); c.e.mem_rd = lw; c.e.mem_wr = sw; sb.push_back(c);
        if (sw) begin exp_ret++; return; end
      end
    end
    c = mk(3'd4, 1'b1, op, fn, z);
    c.e.reg_we = 1'b1;
    if (is_r) c.e.reg_dst = 2'b01;
    else if (lw) c.e.wb_sel = 2'b01;
    else if (op == 6'h03) begin
      c.e.reg_dst = 2'b10; c.e.wb_sel = 2'b10; c.e.pc_we = 1'b1; c.e.pc_src = 2'b10;
    end
    sb.push_back(c);
    exp_ret++;
  endfunction

  // Drives one cycle's inputs, samples mid-cycle, then advances past the next edge.
  task automatic step(input cyc_t c, output ctl_t o);
    opcode = c.op; funct = c.fn; zero = c.zr; mem_ready = c.mr;
    #1;
    o = {state, pc_we, ir_we, mem_rd, mem_wr, reg_we, reg_dst, wb_sel,
         alu_op, alu_src_b, ext_op, pc_src, illegal};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_cmp++;
    if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d exp 0", retired); end
    n_cmp++;
    if ({pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes got %b exp 000000", {pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal});
    end
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_rtype();
    cyc_t c; ctl_t o;
    push_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h23, 1'b1, 0, 0, 1'b0);
    push_instr(6'h00, 6'h24, 1'b0, 1, 0, 1'b0);
    push_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h2a, 1'b0, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL rtype op=%h fn=%h got %h exp %h", c.op, c.fn, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL rtype_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_lw();
    cyc_t c; ctl_t o; int cycles;
    push_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    cycles = sb.size();
    n_cmp++;
    if (cycles != 8) begin n_err++; $display("FAIL lw_model_len got %0d exp 8", cycles); end
    push_instr(6'h23, 6'h15, 1'b1, 2, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL lw st=%0d mr=%b got %h exp %h", c.e.state, c.mr, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL lw_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_beq();
    cyc_t c; ctl_t o;
    push_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    push_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL beq z=%b st=%0d got %h exp %h", c.zr, c.e.state, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL beq_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_jumps();
    cyc_t c; ctl_t o;
    push_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h08, 1'b0, 1, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL jump op=%h st=%0d got %h exp %h", c.op, c.e.state, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL jump_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_illegal();
    cyc_t c; ctl_t o;
    push_instr(6'h3f, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    push_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL illegal op=%h fn=%h got %h exp %h", c.op, c.fn, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL illegal_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    cyc_t c; ctl_t o;
    logic [11:0] tbl [12];
    logic [11:0] pick;
    tbl = '{12'h021, 12'h023, 12'h024, 12'h025, 12'h02a, 12'h008,
            {6'h23, 6'h0}, {6'h2b, 6'h0}, {6'h04, 6'h0}, {6'h09, 6'h0}, {6'h0d, 6'h0}, {6'h0f, 6'h0}};
    push_instr(6'h09, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h0d, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h0f, 6'h00, 1'b0, 0, 0, 1'b0);
    push_instr(6'h2b, 6'h00, 1'b0, 0, 1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      pick = tbl[$urandom_range(11, 0)];
      push_instr(pick[11:6], pick[5:0], 1'($urandom_range(1, 0)),
                 int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b0);
    end
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL b2b op=%h fn=%h st=%0d got %h exp %h", c.op, c.fn, c.e.state, o, c.e); end
      if (o.reg_we && o.mem_wr) begin n_err++; $display("FAIL b2b_exclusive reg_we=1 mem_wr=1 exp not both"); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL b2b_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid_sw();
    cyc_t c; ctl_t o;
    push_instr(6'h2b, 6'h00, 1'b0, 0, 2, 1'b1);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL sw_pre st=%0d got %h exp %h", c.e.state, o, c.e); end
    end
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b1 || state !== 3'd3) begin
      n_err++; $display("FAIL sw_in_mem got mem_wr=%b state=%0d exp 1/3", mem_wr, state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b0) begin n_err++; $display("FAIL sw_abort_mem_wr got %b exp 0", mem_wr); end
    n_cmp++;
    if (state !== 3'd0 || retired !== 32'd0) begin
      n_err++; $display("FAIL sw_abort_state got state=%0d retired=%0d exp 0/0", state, retired);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal} !== 6'b0) begin
      n_err++; $display("FAIL sw_abort_strobes got %b exp 000000", {pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
    push_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      c = sb.pop_front(); step(c, o); n_cmp++;
      if (o !== c.e) begin n_err++; $display("FAIL post_reset st=%0d got %h exp %h", c.e.state, o, c.e); end
    end
    n_cmp++;
    if (retired !== exp_ret) begin n_err++; $display("FAIL post_reset_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  initial begin
    exp_ret = 32'd0;
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk: input, 1 bit, rising-edge clock.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port opcode: input, 6 bits, instruction-register bits [31:26].
REQ-005 Port funct: input, 6 bits, instruction-register bits [5:0].
REQ-006 Port zero: input, 1 bit, ALU equal flag.
REQ-007 Port mem_ready: input, 1 bit, memory access complete this cycle.
REQ-008 Port pc_we: output, 1 bit, PC write enable.
REQ-009 Port ir_we: output, 1 bit, instruction-register load enable.
REQ-010 Port mem_rd: output, 1 bit, memory read request.
REQ-011 Port mem_wr: output, 1 bit, memory write request.
REQ-012 Port reg_we: output, 1 bit, register-file write enable.
REQ-013 Port reg_dst: output, 2 bits, write-register select: 00 = rt, 01 = rd, 10 = register 31.
REQ-014 Port wb_sel: output, 2 bits, write-data select: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-015 Port alu_op: output, 3 bits, ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 100 = slt, 101 = lui.
REQ-016 Port alu_src_b: output, 1 bit, ALU B operand: 0 = register, 1 = extended immediate.
REQ-017 Port ext_op: output, 1 bit, immediate extension: 1 = sign, 0 = zero.
REQ-018 Port pc_src: output, 2 bits, next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs.
REQ-019 Port illegal: output, 1 bit, one-cycle pulse on an unsupported opcode or funct.
REQ-020 Port state: output, 3 bits, current FSM state.
REQ-021 Port retired: output, 32 bits, count of completed instructions.

Function
REQ-022 FSM states SHALL be encoded FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4; codes 5-7 SHALL return to FETCH on the next cycle.
REQ-023 FETCH SHALL assert mem_rd and hold until mem_ready; when mem_ready is 1, it SHALL assert ir_we and pc_we with pc_src = 00, then go to DECODE.
REQ-024 DECODE SHALL route per opcode:
- j (000010): pc_we with pc_src = 10, go to FETCH.
- jal (000011): go to WB.
- Supported R-type, lw, sw, beq, addiu, ori, lui: go to EXEC.
- Any other opcode: pulse illegal, go to FETCH.
REQ-025 Supported R-type (opcode 000000) funct values SHALL be: addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000; any other funct SHALL pulse illegal in DECODE and go to FETCH.
REQ-026 EXEC SHALL behave per instruction:
- R-type: alu_src_b = 0, alu_op from funct; go to WB.
- jr: pc_we with pc_src = 11; go to FETCH.
- lw, sw, addiu: alu_op = add, alu_src_b = 1, ext_op = 1. lw and sw go to MEM; addiu goes to WB.
- ori: alu_op = or, alu_src_b = 1, ext_op = 0; go to WB.
- lui: alu_op = lui, alu_src_b = 1; go to WB.
- beq: alu_op = sub, alu_src_b = 0; pc_we = zero with pc_src = 01; go to FETCH.
REQ-027 MEM SHALL assert mem_rd (lw) or mem_wr (sw) and hold while mem_ready = 0. When mem_ready = 1, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-028 WB SHALL assert reg_we for exactly one cycle with:
- R-type: reg_dst = 01, wb_sel = 00.
- addiu, ori, lui: reg_dst = 00, wb_sel = 00.
- lw: reg_dst = 00, wb_sel = 01.
- jal: reg_dst = 10, wb_sel = 10, plus pc_we with pc_src = 10.
WB SHALL then go to FETCH.
REQ-029 Cycle counts with mem_ready always 1 SHALL be: j 2; beq, jr, jal 3; sw, R-type, immediate-ALU 4; lw 5. Each memory stall cycle SHALL add one cycle.
REQ-030 All outputs except state and retired SHALL be combinational from state, opcode, funct, zero and mem_ready; unused controls SHALL be 0.
REQ-031 retired SHALL increment by 1 on the final cycle of each legal instruction and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 An illegal instruction SHALL NOT increment retired.
REQ-033 reg_we and mem_wr SHALL never both be 1 in the same cycle.

Reset
REQ-034 While rst_n = 0: state = FETCH, retired = 0, and pc_we, ir_we, mem_rd, mem_wr, reg_we and illegal SHALL be forced to 0, regardless of clk.
REQ-035 Reset asserted mid-instruction SHALL abort it with no further write enable asserted; after release, the first cycle SHALL be FETCH.

Verification
REQ-036 Reset release, then addu (funct 100001) with mem_ready = 1 -> states 0,1,2,4; reg_we in WB with reg_dst = 01, wb_sel = 00; retired = 1.
REQ-037 lw with mem_ready low for 3 cycles in MEM -> state holds at 3 for 3 cycles with mem_rd = 1; WB has reg_dst = 00, wb_sel = 01; total 8 cycles.
REQ-038 beq with zero = 1, then beq with zero = 0 -> pc_we with pc_src = 01 in EXEC only for the first; each takes 3 cycles.
REQ-039 jal -> WB has reg_we = 1, reg_dst = 10, wb_sel = 10, pc_we = 1, pc_src = 10; then j -> pc_we in DECODE; 2 cycles.
REQ-040 opcode 111111, then R-type funct 000000 -> illegal pulses once in DECODE for each; retired unchanged; next state FETCH.
REQ-041 rst_n dropped during MEM of sw -> mem_wr is 0 immediately (asynchronously); after release, state = 0 and retired = 0.
